// File: rtl/instr_pkg.sv
// instr_pkg: instruction field layout and loader state encoding shared by the loader and the decoder.
package instr_pkg;
   localparam int TIPO_HI = 31;
   localparam int TIPO_LO = 30;
   localparam int OP_HI = 29;
   localparam int OP_LO = 28;
   localparam int INM_BIT = 27;
   localparam logic [1:0] TIPO_RESERVED = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
   } load_state_t;

   function automatic logic is_reserved(input logic [31:0] w);
      return w[TIPO_HI:TIPO_LO] == TIPO_RESERVED;
   endfunction
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles four little-endian bytes into a word; word_valid pulses once the word is complete.
module byte_word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        take,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic [1:0]  idx,
   output logic        word_valid
);
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         word <= '0;
         idx <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= take && idx == 2'd3;
         if (take) begin
            word[{idx, 3'b000} +: 8] <= data;
            idx <= idx + 2'd1;
         end
      end
   end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: parses a length-prefixed byte stream into 32-bit words, writes them to instruction memory
// and holds the core until a load completes; reserved tipo encodings are counted.
module instr_loader
   import instr_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  words_loaded,
   output logic [CNT_W-1:0]  illegal_cnt
);
   localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(1) << ADDR_W;

   load_state_t state, nxt;
   logic [7:0] len_lo;
   logic [CNT_W-1:0] len, len_in;
   logic hs, begin_s, word_valid;
   logic [1:0] idx;

   assign hs = in_valid && in_ready;
   assign begin_s = start && (state inside {S_IDLE, S_DONE, S_ERROR});
   assign len_in = CNT_W'({in_data, len_lo});

   byte_word_packer packer (
      .clk(clk),
      .rst(rst),
      .clear(begin_s),
      .take(hs && state == S_DATA),
      .data(in_data),
      .word(mem_wdata),
      .idx(idx),
      .word_valid(word_valid)
   );

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: nxt = start ? S_LEN_LO : state;
         S_LEN_LO: nxt = hs ? S_LEN_HI : state;
         S_LEN_HI: if (hs) nxt = len_in == '0 ? S_DONE : {1'b0, len_in} > CAP ? S_ERROR : S_DATA;
         S_DATA: nxt = hs && idx == 2'd3 ? S_WRITE : state;
         S_WRITE: nxt = words_loaded + CNT_W'(1) == len ? S_DONE : S_DATA;
         default: nxt = S_IDLE;
      endcase
   end

   // Flags are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         in_ready <= 1'b0;
         mem_we <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         error <= 1'b0;
         cpu_hold <= 1'b1;
         mem_addr <= '0;
         words_loaded <= '0;
         illegal_cnt <= '0;
         len_lo <= '0;
         len <= '0;
      end else begin
         state <= nxt;
         in_ready <= nxt inside {S_LEN_LO, S_LEN_HI, S_DATA};
         mem_we <= nxt == S_WRITE;
         busy <= nxt inside {S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE};
         done <= nxt == S_DONE;
         error <= nxt == S_ERROR;
         cpu_hold <= nxt != S_DONE;
         if (nxt == S_WRITE) mem_addr <= words_loaded[ADDR_W-1:0];
         if (state == S_LEN_LO && hs) len_lo <= in_data;
         if (state == S_LEN_HI && hs) len <= len_in;
         if (begin_s) begin
            words_loaded <= '0;
            illegal_cnt <= '0;
         end else if (word_valid) begin
            words_loaded <= words_loaded + CNT_W'(1);
            if (is_reserved(mem_wdata)) illegal_cnt <= illegal_cnt + CNT_W'(1);
         end
      end
   end
endmodule
